// File: rtl/apb_spi_slave_if_fifo.sv
// APB register front end for the SPI controller: config regs, TX/RX FIFOs, TX launch FSM, low-power mode tracking.
// Optional define SPI_FIFO_THRESH_EN maps THR at address 4 and makes spif/sptef threshold-based.
module apb_spi_slave_if_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              Preset,
    input  logic              Psel,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [3:0]        Paddr,
    input  logic [DATA_W-1:0] Pwdata,
    output logic [DATA_W-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr,
    input  logic              ss,
    input  logic              tip,
    input  logic [DATA_W-1:0] data_miso,
    input  logic              receive_data,
    output logic              mstr,
    output logic              cpol,
    output logic              cpha,
    output logic              lsbfe,
    output logic              spiswai,
    output logic [2:0]        sppr,
    output logic [2:0]        spr,
    output logic              spi_interrupt_request,
    output logic              send_data,
    output logic [DATA_W-1:0] data_mosi,
    output logic [1:0]        spi_mode
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] A_CR1 = 4'd0, A_CR2 = 4'd1, A_BR = 4'd2, A_SR = 4'd3, A_THR = 4'd4, A_DR = 4'd5;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, BUSY} tx_state_t;
    typedef enum logic [1:0] {M_RUN = 2'b00, M_WAIT = 2'b01, M_STOP = 2'b10} mode_t;

    logic [7:0] cr1, cr2, br, sr;
    logic spie, spe, sptie, ssoe, modfen, spif, sptef, modf, rx_ovf, busy;
    tx_state_t tx_state;
    mode_t mode;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic access, wr, rd, is_dr, addr_err, launch, tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_W-1:0] rd_val;

    assign spie    = cr1[7];
    assign spe     = cr1[6];
    assign sptie   = cr1[5];
    assign mstr    = cr1[4];
    assign cpol    = cr1[3];
    assign cpha    = cr1[2];
    assign ssoe    = cr1[1];
    assign lsbfe   = cr1[0];
    assign modfen  = cr2[4];
    assign spiswai = cr2[1];
    assign sppr    = br[6:4];
    assign spr     = br[2:0];

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

`ifdef SPI_FIFO_THRESH_EN
    logic [7:0] thr;
    logic [3:0] rx_thr;
    assign rx_thr = (thr[7:4] == 4'd0) ? 4'd1 : thr[7:4];
    assign spif   = (32'(rx_cnt) >= 32'(rx_thr));
    assign sptef  = (32'(tx_cnt) <= 32'(thr[3:0]));
`else
    assign spif   = !rx_empty;
    assign sptef  = !tx_full;
`endif

    assign modf = mstr & modfen & !ssoe & !ss;
    assign busy = (tx_state != IDLE);
    assign sr   = {spif, 1'b0, sptef, modf, rx_ovf, tx_full, rx_full, busy};

    assign access = Psel & Penable;
    assign wr     = access & Pwrite;
    assign rd     = access & !Pwrite;
    assign is_dr  = (Paddr == A_DR);
    assign Pready = access;

    always_comb begin
        rd_val   = '0;
        addr_err = 1'b0;
        case (Paddr)
            A_CR1: rd_val = DATA_W'(cr1);
            A_CR2: rd_val = DATA_W'(cr2);
            A_BR:  rd_val = DATA_W'(br);
            A_SR: begin
                rd_val   = DATA_W'(sr);
                addr_err = Pwrite;
            end
`ifdef SPI_FIFO_THRESH_EN
            A_THR: rd_val = DATA_W'(thr);
`endif
            A_DR:  rd_val = rx_empty ? '0 : rx_mem[rx_rp];
            default: addr_err = 1'b1;
        endcase
    end

    assign Pslverr = !Preset & access & (addr_err | (is_dr & Pwrite & tx_full) | (is_dr & !Pwrite & rx_empty));
    assign Prdata  = (!Preset & rd) ? rd_val : '0;

    assign launch  = spe & !tx_empty & !tip;
    assign tx_push = wr & is_dr & !tx_full;
    assign tx_pop  = (tx_state == IDLE) & launch;
    assign rx_pop  = rd & is_dr & !rx_empty;
    // A push into a full RX FIFO is still accepted when a pop frees a slot on the same edge.
    assign rx_push = receive_data & (!rx_full | rx_pop);

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp] <= Pwdata;
        if (rx_push) rx_mem[rx_wp] <= data_miso;
    end

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (receive_data & !rx_push) rx_ovf <= 1'b1;
            else if (rd & (Paddr == A_SR)) rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            cr1 <= 8'h04;
            cr2 <= 8'h00;
            br  <= 8'h00;
`ifdef SPI_FIFO_THRESH_EN
            thr <= 8'h01;
`endif
        end else if (wr) begin
            case (Paddr)
                A_CR1: cr1 <= Pwdata[7:0];
                A_CR2: cr2 <= Pwdata[7:0] & 8'h1B;
                A_BR:  br  <= Pwdata[7:0] & 8'h77;
`ifdef SPI_FIFO_THRESH_EN
                A_THR: thr <= Pwdata[7:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            tx_state  <= IDLE;
            send_data <= 1'b0;
            data_mosi <= '0;
        end else begin
            send_data <= 1'b0;
            case (tx_state)
                IDLE: if (launch) begin
                    tx_state  <= LOAD;
                    send_data <= 1'b1;
                    data_mosi <= tx_mem[tx_rp];
                end
                LOAD:       tx_state <= WAIT_START;
                WAIT_START: if (tip)  tx_state <= BUSY;
                BUSY:       if (!tip) tx_state <= IDLE;
                default:    tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            mode <= M_RUN;
        end else begin
            case (mode)
                M_RUN:  if (!spe) mode <= M_WAIT;
                M_WAIT: if (spiswai) mode <= M_STOP; else if (spe) mode <= M_RUN;
                M_STOP: if (spe) mode <= M_RUN; else if (!spiswai) mode <= M_WAIT;
                default: mode <= M_RUN;
            endcase
        end
    end
    assign spi_mode = mode;

    always_ff @(posedge PCLK) begin
        if (Preset) spi_interrupt_request <= 1'b0;
        else        spi_interrupt_request <= (spie & (spif | modf)) | (sptie & sptef);
    end
endmodule
